// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter steering one of two valid/ready packet streams onto a shared output.
// Optional `ARB_BURST_LIMIT_EN: hand the grant over after MAX_BURST beats if the other port waits.
module mux2_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic [1:0]        gnt
);

  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("mux2_rr_arbiter: MAX_BURST must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;

  logic busy, own_valid, oth_valid, xfer, grant;

  assign busy      = (state_q != IDLE);
  assign own_valid = sel_q ? in1_valid : in0_valid;
  assign oth_valid = sel_q ? in0_valid : in1_valid;

  assign out_valid = busy & own_valid;
  assign out_data  = sel_q ? in1_data : in0_data;
  assign out_last  = sel_q ? in1_last : in0_last;
  assign in0_ready = (state_q == OWN0) & out_ready;
  assign in1_ready = (state_q == OWN1) & out_ready;
  assign xfer      = out_valid & out_ready;

  assign sel = sel_q;
  assign gnt = gnt_q;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in0_valid | in1_valid) begin
          grant   = (in0_valid & in1_valid) ? ~ptr_q : in1_valid;
          state_d = grant ? OWN1 : OWN0;
          ptr_d   = grant;
        end
      end
      OWN0, OWN1: begin
        if (xfer) begin
          if (out_last) begin
            cnt_d = 8'd0;
            if (oth_valid) begin
              state_d = sel_q ? OWN0 : OWN1;
              ptr_d   = ~sel_q;
            end else if (own_valid) begin
              ptr_d = sel_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
`ifdef ARB_BURST_LIMIT_EN
            // Burst budget spent: yield to a waiting peer, otherwise start a fresh budget.
            if (cnt_q == 8'(MAX_BURST - 1)) begin
              cnt_d = 8'd0;
              if (oth_valid) begin
                state_d = sel_q ? OWN0 : OWN1;
                ptr_d   = ~sel_q;
              end
            end
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = 8'd0;
    sel_d = (state_d == OWN1) ? 1'b1 : (state_d == OWN0) ? 1'b0 : sel_q;
    gnt_d = {state_d == OWN1, state_d == OWN0};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      gnt_q   <= 2'b00;
      ptr_q   <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
